// File: rtl/dmx_receiver.sv
// DMX512 receiver: finds break/MAB, decodes 8N2 slots, and strobes out the start code
// and each data slot. States: S_HUNT wait for break | S_BREAK break seen | S_MAB mark-after-break | S_FRAME in slot | S_IDLE between slots
module dmx_receiver #(
  parameter int CLKS_PER_BIT   = 48,
  parameter int BREAK_MIN_CLKS = 1056,
  parameter int MAB_MIN_CLKS   = 96,
  parameter int MAX_SLOTS      = 512
) (
  input  logic       CLK12,
  input  logic       RESET_N,
  input  logic       dmx_data,
  output logic       slot_valid,
  output logic [8:0] slot_index,
  output logic [7:0] slot_byte,
  output logic [7:0] start_code,
  output logic       packet_start,
  output logic       packet_end,
  output logic [9:0] slot_total,
  output logic       frame_error
);

  localparam int LCW = $clog2(BREAK_MIN_CLKS + 1);
  localparam int MCW = $clog2(MAB_MIN_CLKS + 1);
  localparam int BCW = $clog2(CLKS_PER_BIT);
  localparam logic [LCW-1:0] LOW_MAX   = LCW'(BREAK_MIN_CLKS);
  localparam logic [MCW-1:0] MAB_MAX   = MCW'(MAB_MIN_CLKS);
  localparam logic [BCW-1:0] HALF_LOAD = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] FULL_LOAD = BCW'(CLKS_PER_BIT - 1);
  localparam logic [9:0]     SLOT_MAX  = 10'(MAX_SLOTS);

  typedef enum logic [2:0] {S_HUNT, S_BREAK, S_MAB, S_FRAME, S_IDLE} state_t;

  state_t           state_q;
  logic             sync_q, rx_q, rx_prev_q;
  logic [LCW-1:0]   low_cnt_q, low_cnt_d;
  logic [MCW-1:0]   mab_cnt_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [3:0]       bit_idx_q;
  logic [7:0]       data_q;
  logic             first_q, pkt_open_q;
  logic [9:0]       slot_cnt_q, slot_next;
  logic             slot_valid_q, packet_start_q, packet_end_q, frame_error_q;
  logic [8:0]       slot_index_q;
  logic [7:0]       slot_byte_q, start_code_q;
  logic [9:0]       slot_total_q;
  logic             break_hit, rx_fall, bit_tick;

  // Low-run counter is independent of the FSM so a break is caught from any state.
  always_comb begin
    low_cnt_d = low_cnt_q;
    break_hit = 1'b0;
    if (rx_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + LCW'(1);
      break_hit = (low_cnt_d == LOW_MAX);
    end
  end

  assign rx_fall   = rx_prev_q & ~rx_q;
  assign bit_tick  = (bit_cnt_q == '0);
  assign slot_next = slot_cnt_q + 10'd1;

  always_ff @(posedge CLK12) begin
    if (!RESET_N) begin
      state_q        <= S_HUNT;
      sync_q         <= 1'b1;
      rx_q           <= 1'b1;
      rx_prev_q      <= 1'b1;
      low_cnt_q      <= '0;
      mab_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      bit_idx_q      <= '0;
      data_q         <= '0;
      first_q        <= 1'b0;
      pkt_open_q     <= 1'b0;
      slot_cnt_q     <= '0;
      slot_valid_q   <= 1'b0;
      packet_start_q <= 1'b0;
      packet_end_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      slot_index_q   <= '0;
      slot_byte_q    <= '0;
      start_code_q   <= '0;
      slot_total_q   <= '0;
    end else begin
      sync_q         <= dmx_data;
      rx_q           <= sync_q;
      rx_prev_q      <= rx_q;
      low_cnt_q      <= low_cnt_d;
      slot_valid_q   <= 1'b0;
      packet_start_q <= 1'b0;
      packet_end_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      if (break_hit) begin
        state_q    <= S_BREAK;
        pkt_open_q <= 1'b0;
        if (pkt_open_q) begin
          packet_end_q <= 1'b1;
          slot_total_q <= slot_cnt_q;
        end
      end else begin
        case (state_q)
          S_HUNT: begin
          end
          S_BREAK: begin
            if (rx_q) begin
              state_q   <= S_MAB;
              mab_cnt_q <= '0;
            end
          end
          S_MAB: begin
            if (rx_fall) begin
              if (mab_cnt_q == MAB_MAX) begin
                state_q   <= S_FRAME;
                first_q   <= 1'b1;
                bit_cnt_q <= HALF_LOAD;
                bit_idx_q <= '0;
              end else begin
                state_q <= S_HUNT;
              end
            end else if (mab_cnt_q != MAB_MAX) begin
              mab_cnt_q <= mab_cnt_q + MCW'(1);
            end
          end
          S_IDLE: begin
            if (rx_fall) begin
              state_q   <= S_FRAME;
              first_q   <= 1'b0;
              bit_cnt_q <= HALF_LOAD;
              bit_idx_q <= '0;
            end
          end
          S_FRAME: begin
            if (!bit_tick) begin
              bit_cnt_q <= bit_cnt_q - BCW'(1);
            end else begin
              bit_cnt_q <= FULL_LOAD;
              bit_idx_q <= bit_idx_q + 4'd1;
              if (bit_idx_q == 4'd0) begin
                if (rx_q) state_q <= first_q ? S_HUNT : S_IDLE;
              end else if (bit_idx_q <= 4'd8) begin
                data_q <= {rx_q, data_q[7:1]};
              end else if (!rx_q) begin
                // An all-zero byte with a low stop bit is the next break starting.
                state_q       <= S_HUNT;
                frame_error_q <= (data_q != 8'h00);
              end else if (bit_idx_q == 4'd10) begin
                if (first_q) begin
                  start_code_q   <= data_q;
                  packet_start_q <= 1'b1;
                  slot_cnt_q     <= '0;
                  pkt_open_q     <= 1'b1;
                  state_q        <= S_IDLE;
                end else if (slot_cnt_q < SLOT_MAX) begin
                  slot_valid_q <= 1'b1;
                  slot_index_q <= slot_cnt_q[8:0];
                  slot_byte_q  <= data_q;
                  slot_cnt_q   <= slot_next;
                  state_q      <= (slot_next == SLOT_MAX) ? S_HUNT : S_IDLE;
                end else begin
                  state_q <= S_HUNT;
                end
              end
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign slot_valid   = slot_valid_q;
  assign slot_index   = slot_index_q;
  assign slot_byte    = slot_byte_q;
  assign start_code   = start_code_q;
  assign packet_start = packet_start_q;
  assign packet_end   = packet_end_q;
  assign slot_total   = slot_total_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_dmx_receiver.sv
// Directed bench for dmx_receiver: dut_a runs scaled DMX timing (24 clk/bit),
// dut_b runs a fast bit rate so the 512-slot limit fits in a short run.
module tb_dmx_receiver;
  logic clk = 1'b0;
  logic rst_n;
  logic dmx;
  always #5 clk = ~clk;

  logic       a_valid, a_ps, a_pe, a_fe;
  logic [8:0] a_idx;
  logic [7:0] a_byte, a_sc;
  logic [9:0] a_tot;
  logic       b_valid, b_ps, b_pe, b_fe;
  logic [8:0] b_idx;
  logic [7:0] b_byte, b_sc;
  logic [9:0] b_tot;

  dmx_receiver #(.CLKS_PER_BIT(24), .BREAK_MIN_CLKS(528), .MAB_MIN_CLKS(48), .MAX_SLOTS(512)) dut_a (
    .CLK12(clk), .RESET_N(rst_n), .dmx_data(dmx),
    .slot_valid(a_valid), .slot_index(a_idx), .slot_byte(a_byte), .start_code(a_sc),
    .packet_start(a_ps), .packet_end(a_pe), .slot_total(a_tot), .frame_error(a_fe));

  dmx_receiver #(.CLKS_PER_BIT(4), .BREAK_MIN_CLKS(88), .MAB_MIN_CLKS(8), .MAX_SLOTS(512)) dut_b (
    .CLK12(clk), .RESET_N(rst_n), .dmx_data(dmx),
    .slot_valid(b_valid), .slot_index(b_idx), .slot_byte(b_byte), .start_code(b_sc),
    .packet_start(b_ps), .packet_end(b_pe), .slot_total(b_tot), .frame_error(b_fe));

  int n_tests = 0;
  int n_fail  = 0;

  int a_nv = 0, a_nps = 0, a_npe = 0, a_nfe = 0;
  logic [8:0] a_idx_log [0:255];
  logic [7:0] a_byte_log [0:255];
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      if (a_nv < 256) begin
        a_idx_log[a_nv]  = a_idx;
        a_byte_log[a_nv] = a_byte;
      end
      a_nv++;
    end
    if (a_ps === 1'b1) a_nps++;
    if (a_pe === 1'b1) a_npe++;
    if (a_fe === 1'b1) a_nfe++;
  end

  int b_nv = 0, b_nps = 0, b_npe = 0, b_nfe = 0, b_seq_err = 0;
  logic [8:0] b_last_idx = '0;
  logic [7:0] b_last_byte = '0;
  always @(negedge clk) begin
    if (b_valid === 1'b1) begin
      if ((b_idx != 9'd0 && b_idx != b_last_idx + 9'd1) || b_byte != (b_idx[7:0] ^ 8'h3C))
        b_seq_err++;
      b_last_idx  = b_idx;
      b_last_byte = b_byte;
      b_nv++;
    end
    if (b_ps === 1'b1) b_nps++;
    if (b_pe === 1'b1) b_npe++;
    if (b_fe === 1'b1) b_nfe++;
  end

  logic [7:0] tx [0:519];
  int s_nv, s_nps, s_npe, s_nfe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_nv = a_nv; s_nps = a_nps; s_npe = a_npe; s_nfe = a_nfe;
  endtask

  task automatic line(input logic v, input int n);
    dmx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b, input int bp, input logic stop1);
    line(1'b0, bp);
    for (int i = 0; i < 8; i++) line(b[i], bp);
    line(stop1, bp);
    line(1'b1, bp);
  endtask

  task automatic brk(input int bp);
    line(1'b0, 25 * bp);
    line(1'b1, 3 * bp);
  endtask

  task automatic body(input logic [7:0] sc, input int n, input int bp);
    frame(sc, bp, 1'b1);
    for (int i = 0; i < n; i++) frame(tx[i], bp, 1'b1);
  endtask

  task automatic chk_slots(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("slot%0d_idx", i), 32'(a_idx_log[base + i]), i);
      chk($sformatf("slot%0d_byte", i), 32'(a_byte_log[base + i]), 32'(tx[i]));
    end
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_valid"}, 32'(a_valid), 0);
    chk({pfx, "_index"}, 32'(a_idx), 0);
    chk({pfx, "_byte"},  32'(a_byte), 0);
    chk({pfx, "_sc"},    32'(a_sc), 0);
    chk({pfx, "_pstart"}, 32'(a_ps), 0);
    chk({pfx, "_pend"},  32'(a_pe), 0);
    chk({pfx, "_total"}, 32'(a_tot), 0);
    chk({pfx, "_ferr"},  32'(a_fe), 0);
  endtask

  initial begin
    int bp;
    int s_bnv, s_bnps, s_bnpe, s_bnfe, s_berr;
    rst_n = 1'b0;
    dmx   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_zero_outputs("init");
    rst_n = 1'b1;
    line(1'b1, 48);

    for (int i = 0; i < 520; i++) tx[i] = 8'h00;
    tx[0] = 8'hFF; tx[1] = 8'h05; tx[2] = 8'hFF;

    // normal packet
    brk(24);
    snap();
    body(8'h00, 31, 24);
    line(1'b1, 20 * 24);
    chk("norm_pstart", a_nps - s_nps, 1);
    chk("norm_sc", 32'(a_sc), 0);
    chk("norm_valid_cnt", a_nv - s_nv, 31);
    chk("norm_ferr", a_nfe - s_nfe, 0);
    chk_slots(s_nv, 31);
    snap();
    brk(24);
    chk("norm_pend", a_npe - s_npe, 1);
    chk("norm_total", 32'(a_tot), 31);

    // short break, then short MAB
    snap();
    line(1'b0, 480);
    line(1'b1, 72);
    frame(8'h12, 24, 1'b1);
    frame(8'h34, 24, 1'b1);
    line(1'b1, 240);
    chk("rejbrk_pstart", a_nps - s_nps, 0);
    chk("rejbrk_valid", a_nv - s_nv, 0);
    chk("rejbrk_ferr", a_nfe - s_nfe, 0);
    chk("rejbrk_pend", a_npe - s_npe, 0);
    snap();
    line(1'b0, 600);
    line(1'b1, 24);
    frame(8'h00, 24, 1'b1);
    frame(8'h11, 24, 1'b1);
    line(1'b1, 240);
    chk("rejmab_pstart", a_nps - s_nps, 0);
    chk("rejmab_valid", a_nv - s_nv, 0);
    chk("rejmab_pend", a_npe - s_npe, 0);

    // frame error on slot 2
    brk(24);
    snap();
    frame(8'h00, 24, 1'b1);
    frame(8'h10, 24, 1'b1);
    frame(8'h20, 24, 1'b1);
    frame(8'h55, 24, 1'b0);
    frame(8'h30, 24, 1'b1);
    frame(8'h40, 24, 1'b1);
    line(1'b1, 480);
    chk("ferr_cnt", a_nfe - s_nfe, 1);
    chk("ferr_pstart", a_nps - s_nps, 1);
    chk("ferr_valid_cnt", a_nv - s_nv, 2);
    chk("ferr_idx0", 32'(a_idx_log[s_nv]), 0);
    chk("ferr_byte0", 32'(a_byte_log[s_nv]), 32'h10);
    chk("ferr_idx1", 32'(a_idx_log[s_nv + 1]), 1);
    chk("ferr_byte1", 32'(a_byte_log[s_nv + 1]), 32'h20);
    snap();
    brk(24);
    chk("ferr_pend", a_npe - s_npe, 1);
    chk("ferr_total", 32'(a_tot), 2);

    // baud tolerance: -4% and +4% bit periods
    for (int k = 0; k < 2; k++) begin
      bp = (k == 0) ? 23 : 25;
      snap();
      body(8'h00, 31, bp);
      line(1'b1, 20 * bp);
      chk($sformatf("tol%0d_pstart", bp), a_nps - s_nps, 1);
      chk($sformatf("tol%0d_valid_cnt", bp), a_nv - s_nv, 31);
      chk($sformatf("tol%0d_ferr", bp), a_nfe - s_nfe, 0);
      chk_slots(s_nv, 31);
      snap();
      brk(bp);
      chk($sformatf("tol%0d_pend", bp), a_npe - s_npe, 1);
      chk($sformatf("tol%0d_total", bp), 32'(a_tot), 31);
    end

    // reset during slot 10
    snap();
    body(8'hA7, 10, 24);
    chk("prerst_valid_cnt", a_nv - s_nv, 10);
    chk("prerst_sc", 32'(a_sc), 32'hA7);
    line(1'b0, 24);
    for (int i = 0; i < 4; i++) line(tx[10][i], 24);
    rst_n = 1'b0;
    line(1'b0, 3);
    chk_zero_outputs("rst");
    rst_n = 1'b1;
    snap();
    line(1'b0, 4 * 24 - 3);
    line(1'b1, 48);
    for (int i = 11; i < 15; i++) frame(tx[i], 24, 1'b1);
    line(1'b1, 240);
    chk("postrst_valid", a_nv - s_nv, 0);
    chk("postrst_pstart", a_nps - s_nps, 0);
    chk("postrst_ferr", a_nfe - s_nfe, 0);
    snap();
    brk(24);
    chk("postrst_no_pend", a_npe - s_npe, 0);
    snap();
    body(8'h5A, 5, 24);
    line(1'b1, 240);
    chk("postrst_pkt_pstart", a_nps - s_nps, 1);
    chk("postrst_pkt_sc", 32'(a_sc), 32'h5A);
    chk("postrst_pkt_valid_cnt", a_nv - s_nv, 5);
    chk_slots(s_nv, 5);

    // 520-slot packet against the 512-slot limit (dut_b)
    for (int i = 0; i < 520; i++) tx[i] = 8'(i) ^ 8'h3C;
    brk(4);
    s_bnv = b_nv; s_bnps = b_nps; s_bnfe = b_nfe; s_berr = b_seq_err;
    body(8'h00, 520, 4);
    line(1'b1, 80);
    chk("lim_valid_cnt", b_nv - s_bnv, 512);
    chk("lim_last_idx", 32'(b_last_idx), 511);
    chk("lim_last_byte", 32'(b_last_byte), 32'hC3);
    chk("lim_seq_err", b_seq_err - s_berr, 0);
    chk("lim_pstart", b_nps - s_bnps, 1);
    chk("lim_sc", 32'(b_sc), 0);
    chk("lim_ferr", b_nfe - s_bnfe, 0);
    s_bnpe = b_npe;
    brk(4);
    chk("lim_pend", b_npe - s_bnpe, 1);
    chk("lim_total", 32'(b_tot), 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
